// File: rtl/gray_ptr_receiver_if.sv
// Pointer-crossing bus between the source-side pointer logic and the
// destination-domain gray_ptr_receiver.
//   master : drives the Gray pointer and the error clear, observes the results
//   slave  : the receiver itself
interface gray_ptr_receiver_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] gray_in;
  logic             err_clr;
  logic [WIDTH-1:0] ptr_gray;
  logic [WIDTH-1:0] ptr_bin;
  logic [WIDTH-1:0] delta;
  logic             changed;
  logic             err;

  modport master (
    output gray_in,
    output err_clr,
    input  ptr_gray,
    input  ptr_bin,
    input  delta,
    input  changed,
    input  err
  );

  modport slave (
    input  gray_in,
    input  err_clr,
    output ptr_gray,
    output ptr_bin,
    output delta,
    output changed,
    output err
  );
endinterface

// File: rtl/gray_ptr_receiver.sv
// gray_ptr_receiver
//   Destination-domain end of an async-FIFO pointer crossing. The Gray pointer
//   is passed through a SYNC_STAGES-deep synchroniser, decoded to binary and
//   registered. The advance since the previous registered value is reported as
//   delta with a one-cycle changed pulse. All flops use the falling clock edge.
//
//   Build option GRAY_CHECK_EN: when defined, a sticky err flag is raised if
//   more than one Gray bit changes between consecutive synchronised samples;
//   err_clr clears it (a simultaneous new violation wins). When undefined the
//   checker is absent, err is constant 0 and err_clr is ignored.
//
//   The interface instance must be built with the same WIDTH as this module.
module gray_ptr_receiver #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  gray_ptr_receiver_if.slave bus
);

`ifdef GRAY_CHECK_EN
  // True when two or more bits of v are set (clearing the lowest set bit
  // leaves something behind).
  function automatic logic multi_bit_set(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] low_cleared;
    low_cleared   = v & (v - {{(WIDTH-1){1'b0}}, 1'b1});
    multi_bit_set = |low_cleared;
  endfunction
`endif

  // Synchroniser chain; index 0 samples gray_in, the last index is the
  // synchronised pointer that alone feeds the decode logic.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

  logic [WIDTH-1:0] ptr_gray_q, ptr_gray_d;
  logic [WIDTH-1:0] ptr_bin_q,  ptr_bin_d;
  logic [WIDTH-1:0] delta_q,    delta_d;
  logic             changed_q,  changed_d;
  logic             err_q,      err_d;

  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] bin_s;

  // Shift the synchroniser and decode the synchronised Gray value.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sync_s = sync_q[SYNC_STAGES-1];
    // Binary bit i is the XOR of all Gray bits from i upwards.
    bin_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_s[i] = ^(sync_s >> i);
    end
  end

  // Next state of the output register stage: pointer, change report, err.
  always_comb begin
    ptr_gray_d = sync_s;
    ptr_bin_d  = bin_s;
    changed_d  = (bin_s != ptr_bin_q);
    if (bin_s != ptr_bin_q) begin
      // Modulo subtraction: wrap from all-ones to zero yields 1.
      delta_d = bin_s - ptr_bin_q;
    end else begin
      delta_d = '0;
    end
`ifdef GRAY_CHECK_EN
    if (multi_bit_set(sync_s ^ ptr_gray_q)) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
`else
    err_d = 1'b0;
`endif
  end

  // All state on the falling edge; asynchronous active-low reset flushes the
  // pipeline so any in-flight sample is discarded.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      ptr_gray_q <= '0;
      ptr_bin_q  <= '0;
      delta_q    <= '0;
      changed_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      ptr_gray_q <= ptr_gray_d;
      ptr_bin_q  <= ptr_bin_d;
      delta_q    <= delta_d;
      changed_q  <= changed_d;
      err_q      <= err_d;
    end
  end

  assign bus.ptr_gray = ptr_gray_q;
  assign bus.ptr_bin  = ptr_bin_q;
  assign bus.delta    = delta_q;
  assign bus.changed  = changed_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Self-checking bench for gray_ptr_receiver (WIDTH=4, SYNC_STAGES=2).
// A behavioural model keeps a queue of sampled Gray values to represent the
// synchroniser delay and computes pointer, delta, changed and err from the
// pointer arithmetic directly. Inputs change just after the rising edge, the
// DUT acts on the falling edge, outputs are checked at the next rising edge.
module tb_gray_ptr_receiver;
  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int MASK = (1 << W) - 1;

  logic clk;
  logic rst;

  gray_ptr_receiver_if #(.WIDTH(W)) bus_if ();

  gray_ptr_receiver #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int unsigned hist[$];
  int unsigned m_gray, m_bin, m_delta, m_changed, m_err;

  function automatic int unsigned g2b(input int unsigned g);
    int unsigned b = 0;
    for (int i = 0; i < W; i++) b = b ^ (g >> i);
    return b & MASK;
  endfunction

  function automatic int unsigned b2g(input int unsigned b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(0);
    m_gray = 0; m_bin = 0; m_delta = 0; m_changed = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int unsigned s, b;
    bit viol;
    if (!rst) begin
      model_reset();
    end else begin
      hist.push_back(int'(bus_if.gray_in));
      s = hist.pop_front();
      b = g2b(s);
      viol = ($countones(s ^ m_gray) > 1);
      m_changed = (b != m_bin) ? 1 : 0;
      m_delta   = (b - m_bin) & MASK;
`ifdef GRAY_CHECK_EN
      if (viol) m_err = 1;
      else if (bus_if.err_clr) m_err = 0;
`else
      m_err = 0;
`endif
      m_gray = s;
      m_bin  = b;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ptr_gray"}, 32'(bus_if.ptr_gray), m_gray);
    check({tag, ".ptr_bin"},  32'(bus_if.ptr_bin),  m_bin);
    check({tag, ".delta"},    32'(bus_if.delta),    m_delta);
    check({tag, ".changed"},  32'(bus_if.changed),  m_changed);
    check({tag, ".err"},      32'(bus_if.err),      m_err);
  endtask

  // One falling edge (model follows), then compare at the next rising edge.
  task automatic tick(input string tag);
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic hold(input int unsigned g, input int n, input string tag);
    bus_if.gray_in = W'(g);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    int unsigned rb;
    rst            = 1'b0;
    bus_if.gray_in = '0;
    bus_if.err_clr = 1'b0;
    model_reset();

    // Reset state
    #1;
    check("reset.ptr_bin", 32'(bus_if.ptr_bin), 32'd0);
    check("reset.changed", 32'(bus_if.changed), 32'd0);
    tick("reset_hold");
    tick("reset_hold");
    rst = 1'b1;
    tick("idle");

    // Single increments 1,2,3
    hold(4'b0001, 4, "inc1");
    check("inc1.bin", 32'(bus_if.ptr_bin), 32'd1);
    hold(4'b0011, 4, "inc2");
    check("inc2.bin", 32'(bus_if.ptr_bin), 32'd2);
    hold(4'b0010, 4, "inc3");
    check("inc3.bin", 32'(bus_if.ptr_bin), 32'd3);

    // Wrap 15 -> 0 (1000 -> 0000 is a single Gray bit, so no error)
    hold(4'b1000, 4, "to15");
    check("to15.bin", 32'(bus_if.ptr_bin), 32'd15);
    hold(4'b0000, 3, "wrap");
    check("wrap.bin",     32'(bus_if.ptr_bin), 32'd0);
    check("wrap.changed", 32'(bus_if.changed), 32'd1);
    check("wrap.delta",   32'(bus_if.delta),   32'd1);
    tick("wrap_after");

    // Jump 1 -> 3 (two Gray bits)
    hold(4'b0001, 4, "pre_jump");
    hold(4'b0010, 3, "jump");
    check("jump.bin",   32'(bus_if.ptr_bin), 32'd3);
    check("jump.delta", 32'(bus_if.delta),   32'd2);
    hold(4'b0010, 2, "jump_hold");

    // Clear coinciding with another violation, then a lone clear
    bus_if.gray_in = 4'b0001;
    tick("clr_race");
    tick("clr_race");
    bus_if.err_clr = 1'b1;
    tick("clr_race_edge");
    bus_if.err_clr = 1'b0;
    tick("clr_race_after");
    bus_if.err_clr = 1'b1;
    tick("clr_alone");
    bus_if.err_clr = 1'b0;
    tick("clr_alone_after");

    // Asynchronous reset mid-run with ptr_bin=0101
    hold(4'b0111, 4, "to5");
    check("to5.bin", 32'(bus_if.ptr_bin), 32'd5);
    rst = 1'b0;
    model_reset();
    #1;
    check("async_rst.ptr_bin",  32'(bus_if.ptr_bin),  32'd0);
    check("async_rst.ptr_gray", 32'(bus_if.ptr_gray), 32'd0);
    check("async_rst.delta",    32'(bus_if.delta),    32'd0);
    check("async_rst.changed",  32'(bus_if.changed),  32'd0);
    check("async_rst.err",      32'(bus_if.err),      32'd0);
    @(posedge clk);
    #1;
    tick("in_reset");

    // Release with gray_in=0111 -> first update changed=1, delta=0101
    rst = 1'b1;
    tick("rel1");
    tick("rel2");
    tick("rel3");
    check("rel.bin",     32'(bus_if.ptr_bin), 32'd5);
    check("rel.changed", 32'(bus_if.changed), 32'd1);
    check("rel.delta",   32'(bus_if.delta),   32'd5);
    tick("rel4");
    check("rel4.changed", 32'(bus_if.changed), 32'd0);

    // Randomised pointer walk: mostly small advances, occasional arbitrary
    // values and clears, and one reset in the middle.
    rb = 5;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) rb = $urandom_range(0, MASK);
      else if ($urandom_range(0, 1) == 0) rb = (rb + $urandom_range(0, 3)) & MASK;
      bus_if.gray_in = W'(b2g(rb));
      bus_if.err_clr = ($urandom_range(0, 7) == 0);
      if (n == 200) begin
        rst = 1'b0;
        model_reset();
        #1;
        check("rand_rst.ptr_bin", 32'(bus_if.ptr_bin), 32'd0);
        rst = 1'b1;
      end
      tick("rand");
    end
    bus_if.err_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
